// File: rtl/calculator_multi_pkg.sv
// Shared types for the multi-accumulator calculator: button indices, FSM states,
// decoded operations and the (buttons, alt) -> operation decoder.
package calculator_multi_pkg;

   localparam int unsigned BtnUp     = 0;
   localparam int unsigned BtnDown   = 1;
   localparam int unsigned BtnLeft   = 2;
   localparam int unsigned BtnRight  = 3;
   localparam int unsigned BtnCenter = 4;

   typedef enum logic [1:0] {StIdle, StExec, StDiv} state_t;

   typedef enum logic [3:0] {
      OpMul, OpAdd, OpSub, OpClr, OpDiv, OpRem, OpLoad, OpClrAll, OpNop
   } op_t;

   // Priority UP > DOWN > LEFT > RIGHT; CENTER alone or no button is a no-op.
   function automatic op_t decode_op(input logic [4:0] buttons, input logic alt);
      op_t op;
      op = OpNop;
      if (buttons[BtnUp])         op = alt ? OpDiv    : OpMul;
      else if (buttons[BtnDown])  op = alt ? OpClrAll : OpClr;
      else if (buttons[BtnLeft])  op = alt ? OpLoad   : OpAdd;
      else if (buttons[BtnRight]) op = alt ? OpRem    : OpSub;
      return op;
   endfunction

endpackage

// File: rtl/calculator_multi_if.sv
// Button/switch request side and display-facing result side of the calculator.
interface calculator_multi_if #(
   parameter int unsigned BITS = 32,
   parameter int unsigned NACC = 4
);
   localparam int unsigned SW = (NACC > 1) ? $clog2(NACC) : 1;

   logic                   start;
   logic [4:0]             buttons;
   logic                   alt;
   logic [SW-1:0]          acc_sel;
   logic signed [15:0]     switch;
   logic signed [BITS-1:0] accum;
   logic                   ovf;
   logic                   err;
   logic                   busy;
   logic                   done;

   modport master (
      output start, buttons, alt, acc_sel, switch,
      input  accum, ovf, err, busy, done
   );

   modport slave (
      input  start, buttons, alt, acc_sel, switch,
      output accum, ovf, err, busy, done
   );
endinterface

// File: rtl/calculator_multi_sdiv_iter.sv
// Restoring shift-subtract signed divider: works on magnitudes, fixes signs on output.
// valid pulses exactly BITS+1 cycles after start.
module calculator_multi_sdiv_iter #(
   parameter int unsigned BITS = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic signed [BITS-1:0] dividend,
   input  logic signed [BITS-1:0] divisor,
   output logic signed [BITS-1:0] quotient,
   output logic signed [BITS-1:0] remainder,
   output logic                   valid
);
   localparam int unsigned CW = $clog2(BITS + 1);

   logic [BITS-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            run_q, run_d, qneg_q, qneg_d, rneg_q, rneg_d;
   logic [BITS:0]   rem_sh, trial;

   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      rem_sh = {rem_q, quo_q[BITS-1]};
      trial  = rem_sh - {1'b0, dvs_q};
      if (start) begin
         // |MIN| still fits as an unsigned BITS-bit magnitude
         quo_d  = dividend[BITS-1] ? -dividend : dividend;
         dvs_d  = divisor[BITS-1]  ? -divisor  : divisor;
         rem_d  = '0;
         cnt_d  = CW'(BITS);
         run_d  = 1'b1;
         qneg_d = dividend[BITS-1] ^ divisor[BITS-1];
         rneg_d = dividend[BITS-1];
      end else if (run_q) begin
         if (cnt_q != '0) begin
            if (!trial[BITS]) begin
               rem_d = trial[BITS-1:0];
               quo_d = {quo_q[BITS-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[BITS-1:0];
               quo_d = {quo_q[BITS-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
         end else begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
      end
   end

   assign valid     = run_q && (cnt_q == '0);
   assign quotient  = qneg_q ? -quo_q : quo_q;
   assign remainder = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/calculator_multi.sv
// Multi-accumulator button calculator: captures a request in IDLE, commits single-cycle
// ops from EXEC and divide/remainder from DIV, with sticky per-accumulator flags.
module calculator_multi
   import calculator_multi_pkg::*;
#(
   parameter int unsigned BITS = 32,
   parameter int unsigned NACC = 4
) (
   input logic             clk,
   input logic             reset,
   calculator_multi_if.slave bus
);
   localparam int unsigned SW = (NACC > 1) ? $clog2(NACC) : 1;
   localparam logic signed [BITS-1:0] MinVal = {1'b1, {(BITS-1){1'b0}}};

   state_t                 state_q, state_d;
   op_t                    op_q, op_d;
   logic [SW-1:0]          sel_q, sel_d;
   logic signed [BITS-1:0] opnd_q, opnd_d;
   logic signed [BITS-1:0] acc_q [NACC];
   logic signed [BITS-1:0] acc_d [NACC];
   logic [NACC-1:0]        ovf_q, ovf_d, err_q, err_d;
   logic                   done_q, done_d;

   logic signed [BITS-1:0]   cur, sum, diff, quotient, remainder;
   logic signed [2*BITS-1:0] cur_ext, opnd_ext, prod;
   logic                     add_ovf, sub_ovf, mul_ovf, div_ovf, div_start, div_valid;

   assign cur      = acc_q[sel_q];
   assign sum      = cur + opnd_q;
   assign diff     = cur - opnd_q;
   assign cur_ext  = {{BITS{cur[BITS-1]}}, cur};
   assign opnd_ext = {{BITS{opnd_q[BITS-1]}}, opnd_q};
   assign prod     = cur_ext * opnd_ext;
   assign add_ovf  = (cur[BITS-1] == opnd_q[BITS-1]) && (sum[BITS-1] != cur[BITS-1]);
   assign sub_ovf  = (cur[BITS-1] != opnd_q[BITS-1]) && (diff[BITS-1] != cur[BITS-1]);
   assign mul_ovf  = prod[2*BITS-1:BITS] != {BITS{prod[BITS-1]}};
   assign div_ovf  = (cur == MinVal) && (opnd_q == '1);

   calculator_multi_sdiv_iter #(.BITS(BITS)) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .dividend  (cur),
      .divisor   (opnd_q),
      .quotient  (quotient),
      .remainder (remainder),
      .valid     (div_valid)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      sel_d     = sel_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      err_d     = err_q;
      done_d    = 1'b0;
      div_start = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               op_d    = decode_op(bus.buttons, bus.alt);
               sel_d   = bus.acc_sel;
               opnd_d  = BITS'(bus.switch);
               state_d = StExec;
            end
         end
         StExec: begin
            state_d = StIdle;
            done_d  = 1'b1;
            case (op_q)
               OpMul: begin
                  acc_d[sel_q] = prod[BITS-1:0];
                  if (mul_ovf) ovf_d[sel_q] = 1'b1;
               end
               OpAdd: begin
                  acc_d[sel_q] = sum;
                  if (add_ovf) ovf_d[sel_q] = 1'b1;
               end
               OpSub: begin
                  acc_d[sel_q] = diff;
                  if (sub_ovf) ovf_d[sel_q] = 1'b1;
               end
               OpClr: begin
                  acc_d[sel_q] = '0;
                  ovf_d[sel_q] = 1'b0;
                  err_d[sel_q] = 1'b0;
               end
               OpLoad: acc_d[sel_q] = opnd_q;
               OpClrAll: begin
                  acc_d = '{default: '0};
                  ovf_d = '0;
                  err_d = '0;
               end
               OpDiv, OpRem: begin
                  if (opnd_q == '0) begin
                     err_d[sel_q] = 1'b1;
                  end else begin
                     div_start = 1'b1;
                     done_d    = 1'b0;
                     state_d   = StDiv;
                  end
               end
               default: ;
            endcase
         end
         StDiv: begin
            if (div_valid) begin
               state_d = StIdle;
               done_d  = 1'b1;
               if (op_q == OpDiv) begin
                  acc_d[sel_q] = quotient;
                  if (div_ovf) ovf_d[sel_q] = 1'b1;
               end else begin
                  acc_d[sel_q] = remainder;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= OpNop;
         sel_q   <= '0;
         opnd_q  <= '0;
         acc_q   <= '{default: '0};
         ovf_q   <= '0;
         err_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sel_q   <= sel_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign bus.accum = acc_q[bus.acc_sel];
   assign bus.ovf   = ovf_q[bus.acc_sel];
   assign bus.err   = err_q[bus.acc_sel];
   assign bus.busy  = (state_q != StIdle);
   assign bus.done  = done_q;

endmodule
